// File: rtl/disp_pkg.sv
// disp_pkg: shared types, constants and helpers for the display scheduler.
//   disp_state_e : sequencer states (LIVE, OVL_SHOW, GUARD)
//   DIGIT_W      : width of one BCD digit code
//   DIGIT_BLANK  : digit code the display driver renders as blank
//   cnt_width()  : counter width for a tick parameter (never below 1 bit)
//   lz_blank()   : leading-zero blanking of a packed {thous,hund,tens,units}
package disp_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    LIVE     = 2'd0,
    OVL_SHOW = 2'd1,
    GUARD    = 2'd2
  } disp_state_e;

  // A parameter of 1 still needs a 1-bit counter that can hold 0.
  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

  // Blank leading zeros; the units digit is never blanked so 0 reads "   0".
  function automatic logic [4*DIGIT_W-1:0] lz_blank(input logic [4*DIGIT_W-1:0] d,
                                                     input logic en);
    logic [4*DIGIT_W-1:0] r;
    r = d;
    if (en) begin
      if (d[15:12] == 4'h0) r[15:12] = DIGIT_BLANK;
      else                  r[15:12] = d[15:12];
      if (d[15:8] == 8'h00) r[11:8] = DIGIT_BLANK;
      else                  r[11:8] = d[11:8];
      if (d[15:4] == 12'h000) r[7:4] = DIGIT_BLANK;
      else                    r[7:4] = d[7:4];
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_scheduler_tick_timer.sv
// tick_timer: loadable down-counter that parks at zero.
//   clk, rst  : clock and synchronous active-high reset
//   load_i    : load value_i this cycle (takes priority over counting)
//   value_i   : reload value
//   expire_o  : count has reached zero
module tick_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: reload, else decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: shares the four display digits between the live counter
// value and an overlay requester, with leading-zero blanking and blinking.
//   clk, rst                          : clock, synchronous active-high reset
//   live_{units,tens,hund,thous}      : live BCD digits, sampled on live_valid
//   lz_en                             : leading-zero blanking of live digits
//   ovl_req/ovl_data/ovl_blink        : overlay request, digits, blink flag
//   ovl_gnt/ovl_done                  : one-cycle grant / hold-ended pulses
//   units,tens,hund,thous             : registered digit codes (4'hF = blank)
//   showing_ovl                       : overlay currently on the display
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int HOLD_TICKS  = 50_000_000,
  parameter int GUARD_TICKS = 25_000_000,
  parameter int BLINK_TICKS = 12_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] live_units,
  input  logic [DIGIT_W-1:0] live_tens,
  input  logic [DIGIT_W-1:0] live_hund,
  input  logic [DIGIT_W-1:0] live_thous,
  input  logic               live_valid,
  input  logic               lz_en,
  input  logic               ovl_req,
  input  logic [15:0]        ovl_data,
  input  logic               ovl_blink,
  output logic               ovl_gnt,
  output logic               ovl_done,
  output logic [DIGIT_W-1:0] units,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] hund,
  output logic [DIGIT_W-1:0] thous,
  output logic               showing_ovl
);

  localparam int HW = cnt_width(HOLD_TICKS);
  localparam int GW = cnt_width(GUARD_TICKS);
  localparam int BW = cnt_width(BLINK_TICKS);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS - 1);
  localparam logic [GW-1:0] GUARD_LOAD = (GUARD_TICKS > 0) ? GW'(GUARD_TICKS - 1) : '0;
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_TICKS - 1);

  disp_state_e state_q, state_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] ovl_data_q, ovl_data_d;
  logic        ovl_blink_q, ovl_blink_d;
  logic        phase_q, phase_d;           // 1 = blink phase visible
  logic        ovl_end_q, ovl_end_d;       // hold just expired; ovl_done follows
  logic        gnt_q, gnt_d;
  logic        done_q;
  logic        showing_q, showing_d;
  logic [15:0] digits_q, digits_d;
  logic        hold_load_s, guard_load_s, blink_load_s;
  logic        hold_exp_s, guard_exp_s, blink_exp_s;

  tick_timer #(.WIDTH(HW)) u_hold (
    .clk(clk), .rst(rst), .load_i(hold_load_s), .value_i(HOLD_LOAD), .expire_o(hold_exp_s)
  );
  tick_timer #(.WIDTH(GW)) u_guard (
    .clk(clk), .rst(rst), .load_i(guard_load_s), .value_i(GUARD_LOAD), .expire_o(guard_exp_s)
  );
  tick_timer #(.WIDTH(BW)) u_blink (
    .clk(clk), .rst(rst), .load_i(blink_load_s), .value_i(BLINK_LOAD), .expire_o(blink_exp_s)
  );

  // Sequencer next state, latches and timer controls.
  always_comb begin
    state_d      = state_q;
    ovl_data_d   = ovl_data_q;
    ovl_blink_d  = ovl_blink_q;
    phase_d      = phase_q;
    ovl_end_d    = 1'b0;
    gnt_d        = 1'b0;
    hold_load_s  = 1'b0;
    guard_load_s = 1'b0;
    blink_load_s = 1'b0;
    if (live_valid) snap_d = {live_thous, live_hund, live_tens, live_units};
    else            snap_d = snap_q;
    case (state_q)
      LIVE: begin
        if (ovl_req) begin
          state_d      = OVL_SHOW;
          ovl_data_d   = ovl_data;
          ovl_blink_d  = ovl_blink;
          phase_d      = 1'b1;
          gnt_d        = 1'b1;
          hold_load_s  = 1'b1;
          blink_load_s = 1'b1;
        end else begin
          state_d = LIVE;
        end
      end
      OVL_SHOW: begin
        if (hold_exp_s) begin
          ovl_end_d    = 1'b1;
          guard_load_s = 1'b1;
          state_d      = (GUARD_TICKS == 0) ? LIVE : GUARD;
        end else begin
          state_d = OVL_SHOW;
        end
        if (blink_exp_s) begin
          phase_d      = ~phase_q;
          blink_load_s = 1'b1;
        end else begin
          phase_d = phase_q;
        end
      end
      GUARD: begin
        if (guard_exp_s) state_d = LIVE;
        else             state_d = GUARD;
      end
      default: state_d = LIVE;
    endcase
  end

  // Display content follows the state one cycle later, so digits trail ovl_gnt.
  always_comb begin
    showing_d = (state_q == OVL_SHOW);
    if (state_q == OVL_SHOW) begin
      if (ovl_blink_q && !phase_q) digits_d = {4{DIGIT_BLANK}};
      else                         digits_d = ovl_data_q;
    end else begin
      digits_d = lz_blank(snap_q, lz_en);
    end
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LIVE;
      snap_q      <= 16'h0000;
      ovl_data_q  <= 16'h0000;
      ovl_blink_q <= 1'b0;
      phase_q     <= 1'b1;
      ovl_end_q   <= 1'b0;
      gnt_q       <= 1'b0;
      done_q      <= 1'b0;
      showing_q   <= 1'b0;
      digits_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      ovl_data_q  <= ovl_data_d;
      ovl_blink_q <= ovl_blink_d;
      phase_q     <= phase_d;
      ovl_end_q   <= ovl_end_d;
      gnt_q       <= gnt_d;
      done_q      <= ovl_end_q;
      showing_q   <= showing_d;
      digits_q    <= digits_d;
    end
  end

  assign ovl_gnt     = gnt_q;
  assign ovl_done    = done_q;
  assign showing_ovl = showing_q;
  assign thous       = digits_q[15:12];
  assign hund        = digits_q[11:8];
  assign tens        = digits_q[7:4];
  assign units       = digits_q[3:0];

endmodule
